serial_adder: RTL
=================

Name: serial_adder

Overview:
- Bit-serial N-bit adder built around one behavioural full-adder slice and a registered carry.
- Accepts two WIDTH-bit operands plus carry-in over a valid/ready handshake.
- Adds them LSB-first, one bit per clock, and returns a WIDTH-bit sum and carry-out over a second valid/ready handshake.
- Sits downstream of operand sources as the area-cheap alternative to a ripple-carry array of full adders.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 1..64.

Ports:
clk  input  1  system clock; all state updates on the rising edge.
rst  input  1  synchronous, active-high reset.
in_valid  input  1  operand set A/B/Cin is valid.
in_ready  output  1  block can accept operands.
A  input  WIDTH  addend; sampled only on the input handshake.
B  input  WIDTH  addend; sampled only on the input handshake.
Cin  input  1  carry-in; sampled only on the input handshake.
out_valid  output  1  Sum/Cout hold a completed result.
out_ready  input  1  consumer accepts the result.
Sum  output  WIDTH  registered sum, i.e. the low WIDTH bits of A+B+Cin.
Cout  output  1  registered carry-out, i.e. bit WIDTH of A+B+Cin.
busy  output  1  high while in RUN.

Behaviour:
- One clock (clk); reset is synchronous and active-high (rst).
- Reset, and rst sampled high at any edge:
  - state=IDLE, all internal shift, carry and count registers = 0.
  - Sum=0, Cout=0, out_valid=0, busy=0.
  - in_ready=1 from the first cycle after reset deasserts.
  - rst has priority over every other input.
- FSM states: IDLE, RUN, DONE. Moore outputs:
  - in_ready=(state==IDLE)
  - busy=(state==RUN)
  - out_valid=(state==DONE)
- IDLE:
  - Input handshake is in_valid & in_ready at a rising edge.
  - On the handshake: a_sh<=A, b_sh<=B, carry<=Cin, cnt<=0, state<=RUN.
  - in_valid low: stay in IDLE, registers unchanged.
- RUN: each edge computes
  - s=a_sh[0]^b_sh[0]^carry
  - c=(a_sh[0]&b_sh[0])|(a_sh[0]&carry)|(b_sh[0]&carry)
  - a_sh, b_sh shift right by 1 with zero fill.
  - sum_sh<={s, sum_sh[WIDTH-1:1]}, carry<=c, cnt<=cnt+1.
  - When cnt==WIDTH-1, the same edge loads Sum<=final sum_sh (including s), Cout<=c, state<=DONE.
  - cnt width is $clog2(WIDTH+1). WIDTH=1 means a single RUN cycle.
- Latency: with the input handshake at edge E0, out_valid is first high after edge E_WIDTH, i.e. exactly WIDTH cycles later.
- DONE:
  - Sum/Cout are stable.
  - out_valid stays high until out_ready is high at an edge; then state<=IDLE.
  - Sum/Cout keep the last result until the next result overwrites them.
- No overlap:
  - in_ready=0 in RUN and DONE; in_valid is ignored there, and A/B/Cin changes have no effect.
  - The next accept is possible no earlier than the edge after the output handshake.
  - Throughput is therefore one result per WIDTH+2 cycles with zero-stall handshakes.
- out_ready is ignored while out_valid=0.
- Reset mid-RUN or in DONE: the operation is aborted, no out_valid is produced, and Sum/Cout are cleared to 0.
- Arithmetic is exact modulo 2^(WIDTH+1), i.e. {Cout,Sum} == A+B+Cin for all inputs. There are no overflow flags.

Test Plan:
- WIDTH=8, A=0x00 B=0x00 Cin=0 -> out_valid high exactly 8 cycles after accept; Sum=0x00, Cout=0; busy high for 8 cycles.
- WIDTH=8, A=0xFF B=0x01 Cin=0 -> Sum=0x00 Cout=1. Then A=0xA5 B=0x5A Cin=1 -> Sum=0x00 Cout=1. Then A=0x7F B=0x01 Cin=0 -> Sum=0x80 Cout=0.
- Backpressure: hold out_ready=0 for 5 cycles after out_valid, while driving in_valid=1 with A=0x11 B=0x22 -> in_ready=0 throughout; Sum/Cout unchanged; operands not captured. out_ready=1 -> IDLE next cycle, in_ready=1.
- Reset in flight: accept A=0x3C B=0x0F, assert rst for 1 cycle at the 3rd RUN cycle -> out_valid never rises; Sum=0, Cout=0, in_ready=1 after reset. A following A=0x3C B=0x0F Cin=0 -> Sum=0x4B Cout=0.
- WIDTH=1 instance, all 8 {A,B,Cin} combinations -> full-adder truth table on {Cout,Sum}, e.g. 1,1,1 -> Sum=1 Cout=1, with 1-cycle latency.
- WIDTH=8, 1000 random operand sets with random in_valid/out_ready gaps -> {Cout,Sum}==A+B+Cin for every set, and no dropped or duplicated results.

Source files
------------

// File: rtl/serial_adder_if.sv
// Operand and result handshake bundle for the bit-serial adder.
interface serial_adder_if #(
    parameter int unsigned WIDTH = 8
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] A;
    logic [WIDTH-1:0] B;
    logic             Cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] Sum;
    logic             Cout;

    // Operand source / result consumer side
    modport master (
        output in_valid, A, B, Cin, out_ready,
        input  in_ready, out_valid, Sum, Cout
    );

    // Adder side
    modport slave (
        input  in_valid, A, B, Cin, out_ready,
        output in_ready, out_valid, Sum, Cout
    );
endinterface

// File: rtl/serial_adder.sv
// Bit-serial WIDTH-bit adder: one full-adder slice, registered carry, LSB first.
module serial_adder #(
    parameter int unsigned WIDTH = 8
) (
    input  logic           clk,
    input  logic           rst,
    serial_adder_if.slave  bus,
    output logic           busy
);
    localparam int unsigned CW = $clog2(WIDTH + 1);

    // One-hot so each Moore output is a flop bit
    typedef enum logic [2:0] {
        ST_IDLE = 3'b001,
        ST_RUN  = 3'b010,
        ST_DONE = 3'b100
    } state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sh_q, a_sh_d;
    logic [WIDTH-1:0] b_sh_q, b_sh_d;
    logic [WIDTH-1:0] sum_sh_q, sum_sh_d;
    logic             carry_q, carry_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] sum_q, sum_d;
    logic             cout_q, cout_d;
    logic             fa_s, fa_c;

    // State and datapath registers, synchronous reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            a_sh_q   <= '0;
            b_sh_q   <= '0;
            sum_sh_q <= '0;
            carry_q  <= 1'b0;
            cnt_q    <= '0;
            sum_q    <= '0;
            cout_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_sh_q   <= a_sh_d;
            b_sh_q   <= b_sh_d;
            sum_sh_q <= sum_sh_d;
            carry_q  <= carry_d;
            cnt_q    <= cnt_d;
            sum_q    <= sum_d;
            cout_q   <= cout_d;
        end
    end

    // Next-state, full-adder slice and shift datapath
    always_comb begin
        state_d  = state_q;
        a_sh_d   = a_sh_q;
        b_sh_d   = b_sh_q;
        sum_sh_d = sum_sh_q;
        carry_d  = carry_q;
        cnt_d    = cnt_q;
        sum_d    = sum_q;
        cout_d   = cout_q;

        fa_s = a_sh_q[0] ^ b_sh_q[0] ^ carry_q;
        fa_c = (a_sh_q[0] & b_sh_q[0]) | (a_sh_q[0] & carry_q) | (b_sh_q[0] & carry_q);

        unique case (state_q)
            ST_IDLE: begin
                if (bus.in_valid) begin
                    a_sh_d  = bus.A;
                    b_sh_d  = bus.B;
                    carry_d = bus.Cin;
                    cnt_d   = '0;
                    state_d = ST_RUN;
                end
            end
            ST_RUN: begin
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                // Shift-based insert keeps WIDTH=1 legal (no empty slice)
                sum_sh_d = (sum_sh_q >> 1) | (WIDTH'(fa_s) << (WIDTH - 1));
                carry_d  = fa_c;
                cnt_d    = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    sum_d   = sum_sh_d;
                    cout_d  = fa_c;
                    state_d = ST_DONE;
                end
            end
            ST_DONE: begin
                if (bus.out_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign bus.in_ready  = state_q[0];
    assign busy          = state_q[1];
    assign bus.out_valid = state_q[2];
    assign bus.Sum       = sum_q;
    assign bus.Cout      = cout_q;
endmodule
